jt10_adpcma_fetch: RTL



---
 rtl/jt10_adpcma_fetch.sv | 125 ++++++++++++
 1 files changed

// File: rtl/jt10_adpcma_fetch.sv
// jt10_adpcma_fetch: single-channel ADPCM-A nibble fetcher feeding the decoder with data/chon per cen
module jt10_adpcma_fetch #(
   parameter int AW = 24
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen,
   input  logic          keyon,
   input  logic          keyoff,
   input  logic [AW-9:0] start_blk,
   input  logic [AW-9:0] end_blk,
   output logic [AW-1:0] rom_addr,
   output logic          rom_cs,
   input  logic [7:0]    rom_data,
   input  logic          rom_ok,
   output logic [3:0]    data,
   output logic          chon,
   output logic          flag,
   input  logic          clr_flag,
   output logic          underrun
);
   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic          cs_q;
   logic [7:0]    cur_q, nxt_q, cur_d, nxt_d;
   logic          cur_v_q, nxt_v_q, cur_v_d, nxt_v_d;
   logic          cur_last_q, nxt_last_q, cur_last_d, nxt_last_d;
   logic          fetched_last_q, done_q, sel_q;
   logic [3:0]    data_q;
   logic          chon_q, flag_q, underrun_q;
   logic          cap, is_last, play, consume, finish, starve, req, shift_v, to_nxt;
   // Handshake, playback events and the buffer shuffle; a captured byte fills cur if it is empty after this cycle's consumption, else nxt
   always_comb begin
      cap        = cs_q && rom_ok;
      is_last    = addr_q == {end_blk, 8'hFF};
      play       = cen && cur_v_q && state_q != IDLE;
      consume    = play && !sel_q;
      finish     = cen && state_q == PLAY && done_q;
      starve     = consume && !nxt_v_q && !cur_last_q;
      req        = state_q != IDLE && !cs_q && !nxt_v_q && !fetched_last_q;
      shift_v    = consume ? nxt_v_q : cur_v_q;
      to_nxt     = cap && shift_v;
      cur_d      = cap && !shift_v ? rom_data : consume ? nxt_q : cur_q;
      cur_v_d    = shift_v || cap;
      cur_last_d = cap && !shift_v ? is_last : consume ? nxt_last_q : cur_last_q;
      nxt_d      = to_nxt ? rom_data : nxt_q;
      nxt_v_d    = to_nxt || (nxt_v_q && !consume);
      nxt_last_d = to_nxt ? is_last : nxt_last_q;
   end
   // Control FSM, ROM request/address sequencing, buffers and decoder outputs; keyoff beats keyon
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         addr_q         <= '0;
         cs_q           <= 1'b0;
         cur_q          <= '0;
         nxt_q          <= '0;
         cur_v_q        <= 1'b0;
         nxt_v_q        <= 1'b0;
         cur_last_q     <= 1'b0;
         nxt_last_q     <= 1'b0;
         fetched_last_q <= 1'b0;
         done_q         <= 1'b0;
         sel_q          <= 1'b1;
         data_q         <= '0;
         chon_q         <= 1'b0;
         flag_q         <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         flag_q <= (finish && !keyon && !keyoff) || (flag_q && !clr_flag);
         if (keyoff) begin
            state_q <= IDLE;
            cs_q    <= 1'b0;
            chon_q  <= 1'b0;
         end else if (keyon) begin
            state_q        <= LOAD;
            addr_q         <= {start_blk, 8'h00};
            cs_q           <= 1'b0;
            cur_v_q        <= 1'b0;
            nxt_v_q        <= 1'b0;
            fetched_last_q <= 1'b0;
            done_q         <= 1'b0;
            sel_q          <= 1'b1;
            underrun_q     <= 1'b0;
         end else begin
            cur_q      <= cur_d;
            cur_v_q    <= cur_v_d;
            cur_last_q <= cur_last_d;
            nxt_q      <= nxt_d;
            nxt_v_q    <= nxt_v_d;
            nxt_last_q <= nxt_last_d;
            if (cap) begin
               cs_q           <= 1'b0;
               fetched_last_q <= is_last;
               if (!is_last) addr_q <= addr_q + AW'(1);
            end else if (req) begin
               cs_q <= 1'b1;
            end
            if (play) begin
               data_q <= sel_q ? cur_q[7:4] : cur_q[3:0];
               chon_q <= 1'b1;
               sel_q  <= !sel_q;
            end else if (cen) begin
               chon_q <= 1'b0;
            end
            if (consume && cur_last_q) done_q <= 1'b1;
            if (starve) begin
               underrun_q <= 1'b1;
               state_q    <= LOAD;
            end else if (finish) begin
               state_q <= IDLE;
            end else if (state_q == LOAD && cur_v_q) begin
               state_q <= PLAY;
            end
         end
      end
   end
   assign rom_addr = addr_q;
   assign rom_cs   = cs_q;
   assign data     = data_q;
   assign chon     = chon_q;
   assign flag     = flag_q;
   assign underrun = underrun_q;
endmodule
